// File: rtl/board_inputs_pkg.sv
// Shared definitions for the board input path: debug FSM encoding, key/switch roles
// and the registered debug-controller output bundle.
package board_inputs_pkg;

    typedef enum logic [1:0] {
        SRST = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        STEP = 2'd3
    } dbg_state_e;

    localparam int NUM_KEYS      = 4;
    localparam int NUM_SW        = 18;
    localparam int KEY_SRST      = 0;
    localparam int KEY_RUN       = 1;
    localparam int KEY_STEP      = 2;
    localparam int SW_BP_EN      = 16;
    localparam int SW_START_HALT = 17;

    typedef struct packed {
        logic run_en;
        logic halted;
        logic soft_rstn;
    } dbg_out_t;

    function automatic logic bp_hit(input logic sync, input logic en, input logic mask,
                                    input logic [15:0] pc, input logic [15:0] addr);
        return sync & en & ~mask & (pc == addr);
    endfunction

endpackage

// File: rtl/board_inputs_debounce_bit.sv
// One input bit: two-flop synchroniser, tick-sampled stability counter, stable level
// and a registered pulse on each accepted rising level.
module debounce_bit #(
    parameter int STABLE_SAMPLES = 8,
    parameter bit INVERT         = 1'b0
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_tick,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);
    localparam int CW = (STABLE_SAMPLES > 1) ? $clog2(STABLE_SAMPLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

    logic [1:0]    sync_pipe;
    logic [CW-1:0] cnt;
    logic          sample;

    assign sample = sync_pipe[1] ^ INVERT;

    // Sync flops reset to the idle raw level so an inverted key does not look pressed.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync_pipe <= {2{INVERT}};
            cnt       <= '0;
            o_level   <= 1'b0;
            o_rise    <= 1'b0;
        end else begin
            sync_pipe <= {sync_pipe[0], i_raw};
            o_rise    <= 1'b0;
            if (i_tick) begin
                if (sample != o_level) begin
                    if (cnt == CNT_LAST) begin
                        o_level <= sample;
                        o_rise  <= sample;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/board_inputs.sv
// Board input receive path: debounced keys/switches plus the debug controller
// (soft reset, run/halt, single step, PC breakpoint) gating the NES CPU.
module board_inputs
    import board_inputs_pkg::*;
#(
    parameter int TICK_DIV       = 50000,
    parameter int STABLE_SAMPLES = 8,
    parameter int RST_HOLD       = 1024
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic [3:0]  i_KEY,
    input  logic [17:0] i_SW,
    input  logic [15:0] i_nes_cpu_pc,
    input  logic        i_nes_cpu_sync,
    output logic [17:0] o_sw,
    output logic [3:0]  o_key_down,
    output logic [3:0]  o_key_press,
    output logic        o_cpu_run_en,
    output logic        o_cpu_halted,
    output logic        o_soft_rstn
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);

    logic [TW-1:0]     tick_cnt;
    logic              tick;
    logic [NUM_SW-1:0] sw_rise_unused;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            tick     <= 1'b1;
        end else begin
            tick_cnt <= tick_cnt + 1'b1;
            tick     <= 1'b0;
        end
    end

    for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
        debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES), .INVERT(1'b1)) u_db (
            .i_clk(i_clk), .i_rstn(i_rstn), .i_tick(tick), .i_raw(i_KEY[k]),
            .o_level(o_key_down[k]), .o_rise(o_key_press[k])
        );
    end

    for (genvar s = 0; s < NUM_SW; s++) begin : g_sw
        debounce_bit #(.STABLE_SAMPLES(STABLE_SAMPLES), .INVERT(1'b0)) u_db (
            .i_clk(i_clk), .i_rstn(i_rstn), .i_tick(tick), .i_raw(i_SW[s]),
            .o_level(o_sw[s]), .o_rise(sw_rise_unused[s])
        );
    end

    dbg_state_e    state;
    dbg_out_t      dbg_q;
    logic [HW-1:0] hold_cnt;
    logic          bp_mask;
    logic          step_seen;
    logic          hit;

    assign hit = bp_hit(i_nes_cpu_sync, o_sw[SW_BP_EN], bp_mask, i_nes_cpu_pc, o_sw[15:0]);

    assign o_cpu_run_en = dbg_q.run_en;
    assign o_cpu_halted = dbg_q.halted;
    assign o_soft_rstn  = dbg_q.soft_rstn;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state     <= SRST;
            dbg_q     <= '0;
            hold_cnt  <= '0;
            bp_mask   <= 1'b0;
            step_seen <= 1'b0;
        end else begin
            if (state != HALT && i_nes_cpu_sync)
                bp_mask <= 1'b0;
            if (o_key_press[KEY_SRST]) begin
                state    <= SRST;
                dbg_q    <= '0;
                hold_cnt <= '0;
                bp_mask  <= 1'b0;
            end else begin
                case (state)
                    SRST: begin
                        if (hold_cnt == HOLD_LAST) begin
                            dbg_q.soft_rstn <= 1'b1;
                            if (o_sw[SW_START_HALT]) begin
                                state        <= HALT;
                                dbg_q.halted <= 1'b1;
                            end else begin
                                state        <= RUN;
                                dbg_q.run_en <= 1'b1;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                    RUN: begin
                        if (hit || o_key_press[KEY_RUN]) begin
                            state        <= HALT;
                            dbg_q.run_en <= 1'b0;
                            dbg_q.halted <= 1'b1;
                        end
                    end
                    HALT: begin
                        if (o_key_press[KEY_RUN] || o_key_press[KEY_STEP]) begin
                            state        <= o_key_press[KEY_RUN] ? RUN : STEP;
                            dbg_q.run_en <= 1'b1;
                            dbg_q.halted <= 1'b0;
                            bp_mask      <= 1'b1;
                            step_seen    <= 1'b0;
                        end
                    end
                    STEP: begin
                        // The first sync re-issues the stalled fetch; the second is the next opcode.
                        if (o_key_press[KEY_RUN]) begin
                            state <= RUN;
                        end else if (i_nes_cpu_sync) begin
                            if (step_seen) begin
                                state        <= HALT;
                                dbg_q.run_en <= 1'b0;
                                dbg_q.halted <= 1'b1;
                            end else begin
                                step_seen <= 1'b1;
                            end
                        end
                    end
                    default: state <= SRST;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_board_inputs.sv
// Directed bench for board_inputs: debounce vector table plus hand sequences for the
// debug controller (bounce, step, breakpoint, soft reset, async reset).
module tb_board_inputs;
    localparam int TICK_DIV = 4, STABLE_SAMPLES = 3, RST_HOLD = 8;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [3:0]  i_KEY;
    logic [17:0] i_SW;
    logic [15:0] i_nes_cpu_pc;
    logic        i_nes_cpu_sync;
    logic [17:0] o_sw;
    logic [3:0]  o_key_down, o_key_press;
    logic        o_cpu_run_en, o_cpu_halted, o_soft_rstn;

    board_inputs #(.TICK_DIV(TICK_DIV), .STABLE_SAMPLES(STABLE_SAMPLES), .RST_HOLD(RST_HOLD)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_KEY(i_KEY), .i_SW(i_SW),
        .i_nes_cpu_pc(i_nes_cpu_pc), .i_nes_cpu_sync(i_nes_cpu_sync),
        .o_sw(o_sw), .o_key_down(o_key_down), .o_key_press(o_key_press),
        .o_cpu_run_en(o_cpu_run_en), .o_cpu_halted(o_cpu_halted), .o_soft_rstn(o_soft_rstn)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [17:0] sw;
        int          hold;
        logic [17:0] exp_sw;
    } vec_t;

    vec_t vecs[7];
    int   errors = 0, checks = 0;
    int   pulses, ok, coincide;
    logic prev_down;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic press_key(input int idx);
        int found = 0;
        i_KEY[idx] = 1'b0;
        for (int c = 0; c < 20 && found == 0; c++) begin
            step();
            if (o_key_press[idx]) found = 1;
        end
        check($sformatf("press_key%0d_pulse", idx), found, 1);
        i_KEY[idx] = 1'b1;
    endtask

    task automatic fire_sync(input logic [15:0] pc);
        i_nes_cpu_pc   = pc;
        i_nes_cpu_sync = 1'b1;
        step();
        i_nes_cpu_sync = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{18'h2ABCD, 14, 18'h2ABCD};
        vecs[1] = '{18'h15432, 14, 18'h15432};
        vecs[2] = '{18'h3FFFF, 5,  18'h15432};
        vecs[3] = '{18'h15432, 6,  18'h15432};
        vecs[4] = '{18'h00000, 14, 18'h00000};
        vecs[5] = '{18'h00001, 3,  18'h00000};
        vecs[6] = '{18'h00000, 8,  18'h00000};

        i_rstn = 1'b0; i_KEY = 4'hF; i_SW = '0; i_nes_cpu_pc = '0; i_nes_cpu_sync = 1'b0;
        step(3);
        check("reset_outputs", {o_sw, o_key_down, o_key_press, o_cpu_run_en, o_cpu_halted, o_soft_rstn}, 0);

        // 1: soft reset hold after power-on, then RUN
        i_rstn = 1'b1;
        ok = 1;
        for (int c = 0; c < 7; c++) begin
            step();
            if (o_soft_rstn || o_cpu_run_en) ok = 0;
        end
        check("srst_hold_low", ok, 1);
        step();
        check("srst_release", {o_soft_rstn, o_cpu_run_en, o_cpu_halted}, 3'b110);

        for (int i = 0; i < 7; i++) begin
            i_SW = vecs[i].sw;
            step(vecs[i].hold);
            check($sformatf("vec%0d_sw", i), o_sw, vecs[i].exp_sw);
        end
        check("table_still_run", {o_cpu_run_en, o_cpu_halted}, 2'b10);

        // 2: bouncing KEY1 then steady press
        pulses = 0;
        i_KEY[1] = 1'b0;
        for (int c = 0; c < 6; c++) begin step(); pulses += int'(o_key_press[1]); end
        i_KEY[1] = 1'b1;
        for (int c = 0; c < 4; c++) begin step(); pulses += int'(o_key_press[1]); end
        check("bounce_no_pulse", pulses, 0);
        check("bounce_still_run", {o_cpu_run_en, o_cpu_halted}, 2'b10);
        i_KEY[1] = 1'b0;
        pulses = 0; coincide = 1; prev_down = o_key_down[1];
        for (int c = 0; c < 20; c++) begin
            step();
            if (o_key_press[1]) begin
                pulses++;
                if (!o_key_down[1] || prev_down) coincide = 0;
            end
            prev_down = o_key_down[1];
        end
        check("key1_one_pulse", pulses, 1);
        check("key1_pulse_on_rise", coincide, 1);
        check("key1_halt", {o_cpu_run_en, o_cpu_halted}, 2'b01);
        i_KEY[1] = 1'b1;
        pulses = 0;
        for (int c = 0; c < 16; c++) begin step(); pulses += int'(o_key_press[1]); end
        check("release_no_pulse", pulses, 0);
        check("release_key_down", o_key_down[1], 0);
        check("release_still_halt", {o_cpu_run_en, o_cpu_halted}, 2'b01);

        // 3: single step, syncs in cycles +3 and +7 after the press
        press_key(2);
        ok = 1;
        for (int c = 1; c <= 8; c++) begin
            step();
            if (c <= 7 && (!o_cpu_run_en || o_cpu_halted)) ok = 0;
            i_nes_cpu_sync = (c == 3 || c == 7);
        end
        check("step_run_window", ok, 1);
        check("step_end_halt", {o_cpu_run_en, o_cpu_halted}, 2'b01);

        // 4: breakpoint at C004
        i_SW = 18'h1C004;
        step(14);
        check("bp_sw", o_sw, 18'h1C004);
        press_key(1);
        step();
        check("resume_run", {o_cpu_run_en, o_cpu_halted}, 2'b10);
        fire_sync(16'h1234);
        check("sync_other_pc", {o_cpu_run_en, o_cpu_halted}, 2'b10);
        fire_sync(16'hC004);
        check("bp_hit_halt", {o_cpu_run_en, o_cpu_halted}, 2'b01);
        step(14);
        press_key(1);
        step();
        fire_sync(16'hC004);
        step();
        check("bp_masked_resume", {o_cpu_run_en, o_cpu_halted}, 2'b10);
        fire_sync(16'hC004);
        check("bp_rehit", {o_cpu_run_en, o_cpu_halted}, 2'b01);

        // 5: KEY0 during a pending step, restart halted
        i_SW = 18'h3C004;
        step(14);
        press_key(2);
        step(2);
        check("step_pending", {o_cpu_run_en, o_cpu_halted}, 2'b10);
        press_key(0);
        ok = 1;
        for (int c = 0; c < 8; c++) begin
            step();
            if (o_soft_rstn || o_cpu_run_en || o_cpu_halted) ok = 0;
        end
        check("key0_srst_hold", ok, 1);
        step();
        check("key0_exit_halt", {o_soft_rstn, o_cpu_run_en, o_cpu_halted}, 3'b101);

        // 6: async reset in the middle of a debounce
        i_SW = 18'h0F0F0;
        step(6);
        #3 i_rstn = 1'b0;
        #1;
        check("async_reset_outputs",
              {o_sw, o_key_down, o_key_press, o_cpu_run_en, o_cpu_halted, o_soft_rstn}, 0);
        @(posedge i_clk);
        #1 i_rstn = 1'b1;
        step(12);
        check("post_reset_sw_not_yet", o_sw, 18'h0);
        step();
        check("post_reset_sw_exact", o_sw, 18'h0F0F0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
